multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multicycle controller for the CPU datapath. Decodes the instruction register fields and sequences fetch, decode, execute, memory and writeback over several cycles.
- Holds the architectural NZCV flag register and evaluates the condition field.
- Drives every enable and mux select of the PC register, register file, ALU, data memory and PC-source mux.

Parameters:
PC_REG_IDX, 15, register-file index aliased to the PC (R15); writes to it redirect the PC.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
Cond  input  4  instruction[31:28], condition field
Op  input  2  instruction[27:26], class: 00 data-processing, 01 memory, 10 branch
Funct  input  6  instruction[25:20]; [5] immediate, [4:1] cmd, [0] S (data-proc) or L (memory)
Rd  input  4  instruction[15:12], destination register
ALUFlags  input  4  ALU N,Z,C,V from the current cycle
PCWrite  output  1  PC register enable
IRWrite  output  1  instruction register enable
RegWrite  output  1  register file WE3
MemWrite  output  1  data memory WE
AdrSrc  output  1  memory address select: 0 PC, 1 ALU result
ALUSrcA  output  1  0 RD1, 1 PC
ALUSrcB  output  2  00 RD2, 01 extended immediate, 10 constant 4
ResultSrc  output  2  00 ALU out register, 01 memory data, 10 ALU result (direct)
ALUCtrl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ImmSrc  output  2  equals Op
RegSrc  output  2  [0]=(Op==10), [1]=(Op==01)
Flags  output  4  registered NZCV

Behaviour:
- Sequencing
  - Synchronous active-high reset, single clock clk.
  - While rst=1: state<=FETCH, Flags<=0000, all write enables (PCWrite, IRWrite, RegWrite, MemWrite) forced 0.
  - rst asserted mid-instruction aborts it. No partial write occurs in the reset cycle.
- FSM states and transitions; unlisted outputs are 0. Each state lasts 1 cycle.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10 (forms PC+8 for R15). Next by Op:
    - 00 with Funct[5]=1 -> EXECUTEI; 00 with Funct[5]=0 -> EXECUTER.
    - 01 -> MEMADR; 10 -> BRANCH; 11 -> FETCH (undefined, executes as NOP).
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next: Funct[0]=1 -> MEMREAD, else MEMWRITE.
  - MEMREAD: AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegW. Next: FETCH.
  - MEMWRITE: AdrSrc=1, MemW. Next: FETCH.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALU decode. Next: ALUWB.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALU decode. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegW. Next: FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, Br. Next: FETCH.
- Latency (cycles per instruction): LDR 5, STR 4, data-processing 4, branch 3, undefined 2.
- ALU decode on Funct[4:1]:
  - 0100 -> ADD, 0010 -> SUB, 0000 -> AND, 1100 -> ORR; any other -> ADD.
- Condition evaluation: CondEx is combinational from the registered Flags.
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - 1110 and 1111 -> 1.
- Gating
  - RegWrite = RegW & CondEx.
  - MemWrite = MemW & CondEx.
  - PCWrite = FETCH | (CondEx & (Br | (RegW & Rd==PC_REG_IDX))).
  - A failed condition completes the sequence with no architectural write.
- Flag update, at the clock edge ending EXECUTER/EXECUTEI, only when Funct[0]=1 and CondEx=1:
  - NZ <= ALUFlags[3:2].
  - CV <= ALUFlags[1:0] only for ADD/SUB; otherwise CV holds.
- Flags never change in any other state.

Optional Feature:
- Macro: CTRL_CMP_EN.
- Defined: Funct[4:1]=1010 (CMP) decodes to SUB, forces flag update (S implied), and suppresses RegWrite and the Rd==15 PC write in ALUWB.
- Undefined: 1010 decodes as default ADD with normal S/RegWrite handling.

Test Plan:
- rst=1 for 2 cycles, mid-DECODE -> Flags=0000, all write enables 0 during reset. First cycle after release is FETCH with IRWrite=1, PCWrite=1.
- ADD R1 (Op=00, Funct=001000, Cond=1110) -> FETCH, DECODE, EXECUTEI, ALUWB. ALUCtrl=00, ALUSrcB=01, RegWrite=1 only in ALUWB, back in FETCH on cycle 5.
- LDR (Op=01, Funct[0]=1) -> MEMADR, MEMREAD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1). STR (Funct[0]=0) -> MEMWRITE with MemWrite=1, 4 cycles total.
- SUBS (Funct=000101) with ALUFlags=0100 -> Flags=0100. Then BEQ (Op=10, Cond=0000) -> PCWrite=1 in BRANCH. Then BNE -> PCWrite=0 in BRANCH.
- ANDS with ALUFlags=1011, prior Flags=0100 -> Flags=1000 (CV held). ADD with Rd=15 -> PCWrite=1 and RegWrite=1 in ALUWB.
- CTRL_CMP_EN defined, CMP (Funct=010101), ALUFlags=0110 -> ALUCtrl=01, Flags=0110, RegWrite=0 in ALUWB. Undefined -> ALUCtrl=00, RegWrite=1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle CPU sequencer with NZCV flags and condition gating.
// Define CTRL_CMP_EN to decode cmd 1010 as CMP (SUB, implied S, no register write).
module multicycle_control_unit #(
    parameter int PC_REG_IDX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUCtrl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] Flags
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       regw;
        logic       memw;
        logic       br;
        logic       adr_src;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] res_src;
        logic [1:0] alu_ctrl;
    } ctrl_t;

`ifdef CTRL_CMP_EN
    localparam logic CMP_EN = 1'b1;
`else
    localparam logic CMP_EN = 1'b0;
`endif

    state_t     state_q, state_d;
    ctrl_t      ctrl_q;
    logic [3:0] flags_q;
    logic       cond_ex;
    logic       is_cmp;
    logic       n, z, c, v;

    assign is_cmp = CMP_EN && Funct[4:1] == 4'b1010;
    assign {n, z, c, v} = flags_q;

    function automatic logic [1:0] alu_dec(input logic [3:0] cmd, input logic cmp);
        return cmp ? 2'b01 :
               cmd == 4'b0100 ? 2'b00 :
               cmd == 4'b0010 ? 2'b01 :
               cmd == 4'b0000 ? 2'b10 :
               cmd == 4'b1100 ? 2'b11 : 2'b00;
    endfunction

    // Control word for the state being entered; registered so outputs come straight from flops.
    function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] f, input logic cmp);
        ctrl_t k;
        k = '0;
        case (s)
            FETCH:    begin k.pcw = 1'b1; k.irw = 1'b1; k.src_a = 1'b1; k.src_b = 2'b10; k.res_src = 2'b10; end
            DECODE:   begin k.src_a = 1'b1; k.src_b = 2'b10; k.res_src = 2'b10; end
            MEMADR:   k.src_b = 2'b01;
            MEMREAD:  k.adr_src = 1'b1;
            MEMWB:    begin k.res_src = 2'b01; k.regw = 1'b1; end
            MEMWRITE: begin k.adr_src = 1'b1; k.memw = 1'b1; end
            EXECR:    k.alu_ctrl = alu_dec(f[4:1], cmp);
            EXECI:    begin k.src_b = 2'b01; k.alu_ctrl = alu_dec(f[4:1], cmp); end
            ALUWB:    k.regw = !cmp;
            BRANCH:   begin k.src_b = 2'b01; k.res_src = 2'b10; k.br = 1'b1; end
            default:  k = '0;
        endcase
        return k;
    endfunction

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = Op == 2'b00 ? (Funct[5] ? EXECI : EXECR) :
                               Op == 2'b01 ? MEMADR :
                               Op == 2'b10 ? BRANCH : FETCH;
            MEMADR:  state_d = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD: state_d = MEMWB;
            EXECR:   state_d = ALUWB;
            EXECI:   state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        cond_ex = 1'b1;
        case (Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = !z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = !c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = !n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = !v;
            4'b1000: cond_ex = c & !z;
            4'b1001: cond_ex = !c | z;
            4'b1010: cond_ex = n == v;
            4'b1011: cond_ex = n != v;
            4'b1100: cond_ex = !z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            default: cond_ex = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            ctrl_q  <= ctrl_of(FETCH, Funct, is_cmp);
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_of(state_d, Funct, is_cmp);
            // Carry/overflow only carry meaning for arithmetic ops; logical ops keep them.
            if ((state_q == EXECR || state_q == EXECI) && (Funct[0] || is_cmp) && cond_ex) begin
                flags_q[3:2] <= ALUFlags[3:2];
                if (!ctrl_q.alu_ctrl[1])
                    flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign PCWrite   = !rst && (ctrl_q.pcw || (cond_ex && (ctrl_q.br || (ctrl_q.regw && Rd == 4'(PC_REG_IDX)))));
    assign IRWrite   = !rst && ctrl_q.irw;
    assign RegWrite  = !rst && ctrl_q.regw && cond_ex;
    assign MemWrite  = !rst && ctrl_q.memw && cond_ex;
    assign AdrSrc    = ctrl_q.adr_src;
    assign ALUSrcA   = ctrl_q.src_a;
    assign ALUSrcB   = ctrl_q.src_b;
    assign ResultSrc = ctrl_q.res_src;
    assign ALUCtrl   = ctrl_q.alu_ctrl;
    assign ImmSrc    = Op;
    assign RegSrc    = {Op == 2'b01, Op == 2'b10};
    assign Flags     = flags_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: instruction-level model checked against the controller every cycle.
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Cond, Rd, ALUFlags, Flags;
    logic [1:0] Op, ALUSrcB, ResultSrc, ALUCtrl, ImmSrc, RegSrc;
    logic [5:0] Funct;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;

    int          checks = 0;
    int          errors = 0;
    logic        exp_valid = 1'b0;
    logic [21:0] exp_v;
    string       ph;
    logic [3:0]  m_flags;

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUCtrl(ALUCtrl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] act_v();
        return {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                ALUCtrl, ImmSrc, RegSrc, Flags};
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (act_v() !== exp_v) begin
                errors++;
                $display("FAIL %s: got %b expected %b", ph, act_v(), exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Odd condition codes are the negation of the even code below them; 111x always passes.
    function automatic logic cond_ok(input logic [3:0] cd, input logic [3:0] f);
        logic nn, zz, cc, vv, base;
        {nn, zz, cc, vv} = f;
        if (cd[3:1] == 3'b111) return 1'b1;
        base = cd[3:1] == 3'd0 ? zz : cd[3:1] == 3'd1 ? cc : cd[3:1] == 3'd2 ? nn :
               cd[3:1] == 3'd3 ? vv : cd[3:1] == 3'd4 ? (cc && !zz) :
               cd[3:1] == 3'd5 ? (nn == vv) : (!zz && nn == vv);
        return base ^ cd[0];
    endfunction

    task automatic step(input string p);
        logic       ce, cmp, s, pcw, irw, regw, memw, adr, sa;
        logic [1:0] sb, res, alu;
        ce  = cond_ok(Cond, m_flags);
`ifdef CTRL_CMP_EN
        cmp = Funct[4:1] == 4'b1010;
`else
        cmp = 1'b0;
`endif
        s   = Funct[0] || cmp;
        alu = cmp ? 2'd1 : Funct[4:1] == 4'b0010 ? 2'd1 : Funct[4:1] == 4'b0000 ? 2'd2 :
              Funct[4:1] == 4'b1100 ? 2'd3 : 2'd0;
        {pcw, irw, regw, memw, adr, sa, sb, res} = '0;
        if (p == "FETCH") begin pcw = 1; irw = 1; sa = 1; sb = 2; res = 2; end
        if (p == "DECODE") begin sa = 1; sb = 2; res = 2; end
        if (p == "MEMADR") sb = 1;
        if (p == "MEMREAD") adr = 1;
        if (p == "MEMWB") begin res = 1; regw = ce; pcw = ce && Rd == 4'd15; end
        if (p == "MEMWRITE") begin adr = 1; memw = ce; end
        if (p == "EXECI") sb = 1;
        if (p == "ALUWB") begin regw = ce && !cmp; pcw = ce && !cmp && Rd == 4'd15; end
        if (p == "BRANCH") begin sb = 1; res = 2; pcw = ce; end
        if (!(p == "EXECR" || p == "EXECI")) alu = 2'd0;
        ph = p;
        exp_v = {pcw, irw, regw, memw, adr, sa, sb, res, alu, Op, Op == 2'b01, Op == 2'b10, m_flags};
        exp_valid = 1'b1;
        @(posedge clk); #1;
        if ((p == "EXECR" || p == "EXECI") && s && ce) begin
            m_flags[3:2] = ALUFlags[3:2];
            if (alu < 2'd2) m_flags[1:0] = ALUFlags[1:0];
        end
    endtask

    task automatic instr(input logic [3:0] cd, input logic [1:0] op, input logic [5:0] fn,
                         input logic [3:0] rd, input logic [3:0] af);
        Cond = cd; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
        step("FETCH");
        step("DECODE");
        if (op == 2'b00) begin
            step(fn[5] ? "EXECI" : "EXECR");
            step("ALUWB");
        end else if (op == 2'b01) begin
            step("MEMADR");
            if (fn[0]) begin step("MEMREAD"); step("MEMWB"); end
            else step("MEMWRITE");
        end else if (op == 2'b10) begin
            step("BRANCH");
        end
    endtask

    initial begin
        rst = 1'b1; Cond = 4'he; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0; m_flags = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", 32'(Flags), 32'h0);
        chk("reset_we", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'h0);
        rst = 1'b0;
        #1;
        chk("release_fetch_we", 32'({IRWrite, PCWrite}), 32'h3);
        instr(4'he, 2'b00, 6'b001000, 4'd1, 4'b0000);
        instr(4'he, 2'b01, 6'b011001, 4'd2, 4'b0000);
        instr(4'he, 2'b01, 6'b011000, 4'd2, 4'b0000);
        instr(4'he, 2'b00, 6'b000101, 4'd3, 4'b0100);
        exp_valid = 1'b0;
        chk("subs_flags", 32'(Flags), 32'h4);
        instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
        instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000);
        instr(4'he, 2'b00, 6'b000001, 4'd4, 4'b1011);
        exp_valid = 1'b0;
        chk("ands_flags_cv_held", 32'(Flags), 32'h8);
        instr(4'he, 2'b00, 6'b001000, 4'd15, 4'b0000);
        instr(4'h0, 2'b00, 6'b001000, 4'd2, 4'b1111);
        instr(4'h5, 2'b01, 6'b000000, 4'd2, 4'b0000);
        instr(4'hb, 2'b00, 6'b011001, 4'd5, 4'b0101);
        exp_valid = 1'b0;
        chk("orrs_lt_flags", 32'(Flags), 32'h4);
        instr(4'he, 2'b11, 6'b000000, 4'd0, 4'b0000);
        instr(4'he, 2'b01, 6'b000001, 4'd15, 4'b0000);
        instr(4'he, 2'b00, 6'b010101, 4'd6, 4'b0110);
        exp_valid = 1'b0;
        chk("cmp_flags", 32'(Flags), 32'h6);
        instr(4'h1, 2'b00, 6'b000101, 4'd7, 4'b1111);
        exp_valid = 1'b0;
        chk("failed_subs_flags_hold", 32'(Flags), 32'h6);
        Cond = 4'he; Op = 2'b00; Funct = 6'b001000; Rd = 4'd3; ALUFlags = 4'b0000;
        step("FETCH");
        exp_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_in_decode_we", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'h0);
        @(posedge clk); #1;
        chk("rst_mid_flags", 32'(Flags), 32'h0);
        chk("rst_mid_we", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'h0);
        @(posedge clk); #1;
        chk("rst_mid_we2", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'h0);
        rst = 1'b0;
        m_flags = 4'd0;
        #1;
        chk("rerelease_fetch_we", 32'({IRWrite, PCWrite}), 32'h3);
        instr(4'he, 2'b00, 6'b001111, 4'd8, 4'b0011);
        exp_valid = 1'b0;
        chk("default_adds_flags", 32'(Flags), 32'h3);
        instr(4'h8, 2'b10, 6'b000000, 4'd0, 4'b0000);
        exp_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
